// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module      : multicycle_ctrl
// Description : Multi-cycle MIPS control FSM with memory-ready timeout trap,
//               illegal-opcode trap and saturating retired-instruction count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl #(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 3,
    parameter int TMO_CYC = 16,
    parameter int CNT_W   = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [OP_W-1:0]    instr_op_i,
    input  logic               mem_ready_i,
    output logic               pc_write_o,
    output logic               pc_write_cond_o,
    output logic               branch_ne_o,
    output logic               iord_o,
    output logic               mem_read_o,
    output logic               mem_write_o,
    output logic               ir_write_o,
    output logic               reg_dst_o,
    output logic               mem_to_reg_o,
    output logic               reg_write_o,
    output logic               alu_src_a_o,
    output logic [1:0]         alu_src_b_o,
    output logic [ALUOP_W-1:0] alu_op_o,
    output logic [1:0]         pc_src_o,
    output logic [3:0]         state_o,
    output logic               trap_o,
    output logic               timeout_o,
    output logic [CNT_W-1:0]   retired_o
);

    localparam int WAIT_W = $clog2(TMO_CYC + 1);

    localparam logic [OP_W-1:0] c_op_r    = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] c_op_lw   = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] c_op_sw   = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] c_op_beq  = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] c_op_bne  = OP_W'(6'b000101);
    localparam logic [OP_W-1:0] c_op_addi = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] c_op_slti = OP_W'(6'b001010);
    localparam logic [OP_W-1:0] c_op_lui  = OP_W'(6'b001111);
    localparam logic [OP_W-1:0] c_op_ori  = OP_W'(6'b001101);
    localparam logic [OP_W-1:0] c_op_j    = OP_W'(6'b000010);

    localparam logic [WAIT_W-1:0] c_wait_last = WAIT_W'(TMO_CYC - 1);

    typedef enum logic [3:0] {
        S_RST      = 4'b0000,
        S_FETCH    = 4'b0001,
        S_DECODE   = 4'b0010,
        S_EXEC_R   = 4'b0011,
        S_R_WB     = 4'b0100,
        S_EXEC_I   = 4'b0101,
        S_I_WB     = 4'b0110,
        S_MEM_ADDR = 4'b0111,
        S_MEM_RD   = 4'b1000,
        S_MEM_WB   = 4'b1001,
        S_MEM_WR   = 4'b1010,
        S_BRANCH   = 4'b1011,
        S_JUMP     = 4'b1100,
        S_RETIRE   = 4'b1101,
        S_TRAP     = 4'b1110
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [WAIT_W-1:0] r_wait;
    logic [CNT_W-1:0]  r_retired;
    logic              r_timeout;
    logic              w_mem_wait;
    logic              w_expired;

    // Only the three memory-handshake states look at mem_ready_i.
    assign w_mem_wait = (r_state == S_FETCH) || (r_state == S_MEM_RD) ||
                        (r_state == S_MEM_WR);
    assign w_expired  = w_mem_wait && !mem_ready_i && (r_wait == c_wait_last);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= S_RST;
            r_wait    <= '0;
            r_retired <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_mem_wait && !mem_ready_i)
                r_wait <= r_wait + 1'b1;
            else
                r_wait <= '0;
            if (r_state == S_RETIRE && r_retired != {CNT_W{1'b1}})
                r_retired <= r_retired + 1'b1;
            if (w_expired)
                r_timeout <= 1'b1;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        pc_write_o      = 1'b0;
        pc_write_cond_o = 1'b0;
        branch_ne_o     = 1'b0;
        iord_o          = 1'b0;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        ir_write_o      = 1'b0;
        reg_dst_o       = 1'b0;
        mem_to_reg_o    = 1'b0;
        reg_write_o     = 1'b0;
        alu_src_a_o     = 1'b0;
        alu_src_b_o     = 2'b00;
        alu_op_o        = '0;
        pc_src_o        = 2'b00;
        case (r_state)
            S_RST: w_next_state = S_FETCH;
            S_FETCH: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = 2'b01;
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
                if (mem_ready_i)    w_next_state = S_DECODE;
                else if (w_expired) w_next_state = S_TRAP;
            end
            S_DECODE: begin
                alu_src_b_o = 2'b11;
                case (instr_op_i)
                    c_op_r:                              w_next_state = S_EXEC_R;
                    c_op_lw, c_op_sw:                    w_next_state = S_MEM_ADDR;
                    c_op_beq, c_op_bne:                  w_next_state = S_BRANCH;
                    c_op_addi, c_op_slti, c_op_lui, c_op_ori: w_next_state = S_EXEC_I;
                    c_op_j:                              w_next_state = S_JUMP;
                    default:                             w_next_state = S_TRAP;
                endcase
            end
            S_EXEC_R: begin
                alu_src_a_o  = 1'b1;
                alu_op_o     = ALUOP_W'(3'b010);
                w_next_state = S_R_WB;
            end
            S_R_WB: begin
                reg_write_o  = 1'b1;
                reg_dst_o    = 1'b1;
                w_next_state = S_RETIRE;
            end
            S_EXEC_I: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                case (instr_op_i)
                    c_op_addi: alu_op_o = ALUOP_W'(3'b100);
                    c_op_slti: alu_op_o = ALUOP_W'(3'b101);
                    c_op_lui:  alu_op_o = ALUOP_W'(3'b110);
                    c_op_ori:  alu_op_o = ALUOP_W'(3'b111);
                    default:   alu_op_o = '0;
                endcase
                w_next_state = S_I_WB;
            end
            S_I_WB: begin
                reg_write_o  = 1'b1;
                w_next_state = S_RETIRE;
            end
            S_MEM_ADDR: begin
                alu_src_a_o  = 1'b1;
                alu_src_b_o  = 2'b10;
                w_next_state = (instr_op_i == c_op_lw) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read_o = 1'b1;
                iord_o     = 1'b1;
                if (mem_ready_i)    w_next_state = S_MEM_WB;
                else if (w_expired) w_next_state = S_TRAP;
            end
            S_MEM_WB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
                w_next_state = S_RETIRE;
            end
            S_MEM_WR: begin
                mem_write_o = 1'b1;
                iord_o      = 1'b1;
                if (mem_ready_i)    w_next_state = S_RETIRE;
                else if (w_expired) w_next_state = S_TRAP;
            end
            S_BRANCH: begin
                alu_src_a_o     = 1'b1;
                alu_op_o        = ALUOP_W'(3'b001);
                pc_src_o        = 2'b01;
                pc_write_cond_o = 1'b1;
                branch_ne_o     = (instr_op_i == c_op_bne);
                w_next_state    = S_RETIRE;
            end
            S_JUMP: begin
                pc_src_o     = 2'b10;
                pc_write_o   = 1'b1;
                w_next_state = S_RETIRE;
            end
            S_RETIRE: w_next_state = S_FETCH;
            S_TRAP:   w_next_state = S_TRAP;
            default:  w_next_state = S_RST;
        endcase
    end

    assign state_o   = r_state;
    assign trap_o    = (r_state == S_TRAP);
    assign timeout_o = r_timeout;
    assign retired_o = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// Module      : tb_multicycle_ctrl
// Description : Directed self-checking bench for multicycle_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  op = 6'b001000;
    logic        ready = 1'b1;
    logic        rst2 = 1'b1;

    logic        pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write;
    logic        ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0]  alu_src_b, pc_src;
    logic [2:0]  alu_op;
    logic [3:0]  state;
    logic        trap, timeout;
    logic [15:0] retired;

    logic        u2_pcw, u2_pcwc, u2_bne, u2_iord, u2_mr, u2_mw, u2_irw;
    logic        u2_rdst, u2_m2r, u2_rw, u2_sa, u2_trap, u2_tmo;
    logic [1:0]  u2_sb, u2_pcs;
    logic [2:0]  u2_aop;
    logic [3:0]  u2_state;
    logic [1:0]  u2_retired;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk_i(clk), .rst_i(rst), .instr_op_i(op), .mem_ready_i(ready),
        .pc_write_o(pc_write), .pc_write_cond_o(pc_write_cond), .branch_ne_o(branch_ne),
        .iord_o(iord), .mem_read_o(mem_read), .mem_write_o(mem_write), .ir_write_o(ir_write),
        .reg_dst_o(reg_dst), .mem_to_reg_o(mem_to_reg), .reg_write_o(reg_write),
        .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b), .alu_op_o(alu_op), .pc_src_o(pc_src),
        .state_o(state), .trap_o(trap), .timeout_o(timeout), .retired_o(retired)
    );

    multicycle_ctrl #(.CNT_W(2)) dut2 (
        .clk_i(clk), .rst_i(rst2), .instr_op_i(6'b000000), .mem_ready_i(1'b1),
        .pc_write_o(u2_pcw), .pc_write_cond_o(u2_pcwc), .branch_ne_o(u2_bne),
        .iord_o(u2_iord), .mem_read_o(u2_mr), .mem_write_o(u2_mw), .ir_write_o(u2_irw),
        .reg_dst_o(u2_rdst), .mem_to_reg_o(u2_m2r), .reg_write_o(u2_rw),
        .alu_src_a_o(u2_sa), .alu_src_b_o(u2_sb), .alu_op_o(u2_aop), .pc_src_o(u2_pcs),
        .state_o(u2_state), .trap_o(u2_trap), .timeout_o(u2_tmo), .retired_o(u2_retired)
    );

    // Every control output packed together for "all outputs zero" checks.
    wire [17:0] all_outs = {pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write,
                            ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                            alu_src_b, alu_op, pc_src};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset state
        cyc(2);
        chk("rst_state", 32'(state), 32'h0);
        chk("rst_outs", 32'(all_outs), 32'h0);
        chk("rst_retired", 32'(retired), 32'h0);
        chk("rst_trap", 32'({trap, timeout}), 32'h0);
        rst = 1'b0;
        #1 chk("rst_hold", 32'(state), 32'h0);

        // ADDI with mem_ready tied high
        cyc(1);
        chk("addi_fetch_state", 32'(state), 32'h1);
        chk("addi_fetch_en", 32'({mem_read, ir_write, pc_write, iord, alu_src_a, alu_src_b}), 32'b11100_01);
        cyc(1);
        chk("addi_decode", 32'({state, alu_src_b, alu_op}), {23'd0, 4'h2, 2'b11, 3'b000});
        cyc(1);
        chk("addi_exec", 32'({state, alu_src_a, alu_src_b, alu_op}), {22'd0, 4'h5, 1'b1, 2'b10, 3'b100});
        cyc(1);
        chk("addi_wb", 32'({state, reg_write, reg_dst, mem_to_reg}), {25'd0, 4'h6, 3'b100});
        cyc(1);
        chk("addi_retire", 32'({state, retired}), {12'd0, 4'hD, 16'd0});
        cyc(1);
        chk("addi_retired", 32'({state, retired}), {12'd0, 4'h1, 16'd1});

        // LW with three wait cycles in MEM_RD
        op = 6'b100011;
        cyc(2);
        chk("lw_memaddr", 32'({state, alu_src_a, alu_src_b, alu_op}), {22'd0, 4'h7, 1'b1, 2'b10, 3'b000});
        ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            if (i == 3) begin
                ready = 1'b1;
                #1;
            end
            chk("lw_memrd", 32'({state, mem_read, iord, reg_write}), {25'd0, 4'h8, 3'b110});
        end
        cyc(1);
        chk("lw_memwb", 32'({state, reg_write, mem_to_reg, reg_dst, mem_read}), {24'd0, 4'h9, 4'b1100});
        cyc(2);
        chk("lw_retired", 32'({state, retired}), {12'd0, 4'h1, 16'd2});

        // BNE then BEQ
        op = 6'b000101;
        cyc(2);
        chk("bne_branch", 32'({state, pc_write_cond, branch_ne, alu_op, pc_src, alu_src_a}),
            {20'd0, 4'hB, 1'b1, 1'b1, 3'b001, 2'b01, 1'b1});
        cyc(2);
        op = 6'b000100;
        cyc(2);
        chk("beq_branch", 32'({state, pc_write_cond, branch_ne, pc_write}), {25'd0, 4'hB, 3'b100});
        cyc(2);
        chk("branch_retired", 32'(retired), 32'd4);

        // J
        op = 6'b000010;
        cyc(2);
        chk("jump", 32'({state, pc_write, pc_src, pc_write_cond}), {24'd0, 4'hC, 1'b1, 2'b10, 1'b0});
        cyc(2);

        // SW, write completes on first cycle
        op = 6'b101011;
        cyc(3);
        chk("sw_memwr", 32'({state, mem_write, iord, mem_read}), {25'd0, 4'hA, 3'b110});
        cyc(1);
        chk("sw_retire", 32'(state), 32'hD);
        cyc(1);
        chk("sw_retired", 32'(retired), 32'd6);

        // Illegal opcode traps, enables held low
        op = 6'b111111;
        cyc(2);
        chk("illegal_trap", 32'({state, trap, timeout}), {26'd0, 4'hE, 2'b10});
        for (int i = 0; i < 20; i++) begin
            ready = i[0];
            cyc(1);
            chk("trap_hold", 32'({state, all_outs}), {10'd0, 4'hE, 18'd0});
        end

        // Async reset clears the trap mid-cycle
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("rst_abort", 32'({state, trap, retired}), 32'h0);
        op = 6'b001000;
        ready = 1'b0;
        cyc(1);
        rst = 1'b0;

        // Ready arriving on the TMO_CYC-th wait cycle completes normally
        cyc(16);
        chk("tmo_edge_fetch", 32'(state), 32'h1);
        ready = 1'b1;
        #1 chk("tmo_edge_irw", 32'({ir_write, pc_write}), 32'b11);
        cyc(1);
        chk("tmo_edge_ok", 32'({state, trap, timeout}), {26'd0, 4'h2, 2'b00});
        cyc(3);
        chk("tmo_retire", 32'(state), 32'hD);

        // Full timeout in FETCH
        ready = 1'b0;
        cyc(16);
        chk("tmo_last_fetch", 32'({state, timeout}), {27'd0, 4'h1, 1'b0});
        cyc(1);
        chk("tmo_trap", 32'({state, trap, timeout}), {26'd0, 4'hE, 2'b11});
        rst = 1'b1;
        #1 chk("tmo_rst", 32'({state, all_outs, trap, timeout, retired}), 32'h0);
        cyc(1);
        rst = 1'b0;

        // Saturation with CNT_W=2
        rst2 = 1'b0;
        cyc(11);
        chk("sat_two", 32'(u2_retired), 32'd2);
        cyc(5);
        chk("sat_three", 32'(u2_retired), 32'd3);
        cyc(10);
        chk("sat_hold", 32'({u2_state, u2_retired}), {26'd0, 4'h1, 2'd3});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
